// File: rtl/i2c_target_regfile.sv
// i2c_target_regfile: oversampling I2C target with a 2^NREGS_LOG2 x 8 register
// file. The address phase selects DEV_ADDR, the first written byte loads the
// register pointer, and further bytes are written or read with a pointer that
// auto-increments. SDA is driven open-drain through sda_oe_o. SCL is never driven.
module i2c_target_regfile #(
  parameter logic [6:0] DEV_ADDR   = 7'h39,
  parameter int         NREGS_LOG2 = 8,
  parameter logic [7:0] RESET_VAL  = 8'h00
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  scl_i,
  input  logic                  sda_i,
  output logic                  sda_oe_o,
  output logic                  wr_stb_o,
  output logic [NREGS_LOG2-1:0] wr_addr_o,
  output logic [7:0]            wr_data_o,
  input  logic [NREGS_LOG2-1:0] rd_addr_i,
  output logic [7:0]            rd_data_o,
  output logic                  busy_o
);

  localparam int NREGS = 1 << NREGS_LOG2;

  // ACK_R / ACK_W / MACK split the ninth bit of REG / WDATA / RDATA into their
  // own states so that each byte phase only counts data bits.
  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_ADDR   = 4'd1,
    S_ACK_A  = 4'd2,
    S_REG    = 4'd3,
    S_ACK_R  = 4'd4,
    S_WDATA  = 4'd5,
    S_ACK_W  = 4'd6,
    S_RDATA  = 4'd7,
    S_MACK   = 4'd8,
    S_IGNORE = 4'd9
  } state_t;

  // Synchronizers and history flops (reset to the idle-high bus level).
  logic r_scl_meta, r_scl_sync, r_scl_hist;
  logic r_sda_meta, r_sda_sync, r_sda_hist;

  // FSM state and datapath registers.
  state_t                r_state;
  logic [3:0]            r_bitcnt;
  logic [7:0]            r_shift;
  logic                  r_mack;
  logic [NREGS_LOG2-1:0] r_ptr;
  logic                  r_sda_oe;
  logic                  r_busy;
  logic                  r_wr_stb;
  logic [NREGS_LOG2-1:0] r_wr_addr;
  logic [7:0]            r_wr_data;
  logic [7:0]            r_rd_data;
  logic [7:0]            r_regs [NREGS];

  // Next-state values produced by the combinational process.
  state_t                w_state_nxt;
  logic [3:0]            w_bitcnt_nxt;
  logic [7:0]            w_shift_nxt;
  logic                  w_mack_nxt;
  logic [NREGS_LOG2-1:0] w_ptr_nxt;
  logic                  w_sda_oe_nxt;
  logic                  w_busy_nxt;
  logic                  w_wr_stb_nxt;
  logic [NREGS_LOG2-1:0] w_wr_addr_nxt;
  logic [7:0]            w_wr_data_nxt;
  logic                  w_we;

  // Bus events decoded from the synchronized samples.
  logic                  w_scl_rise, w_scl_fall, w_start, w_stop;
  logic [NREGS_LOG2-1:0] w_ptr_inc;
  logic [7:0]            w_rd_cur, w_rd_inc;

  assign w_scl_rise = r_scl_sync & ~r_scl_hist;
  assign w_scl_fall = ~r_scl_sync & r_scl_hist;
  assign w_start    = r_scl_sync & r_scl_hist & r_sda_hist & ~r_sda_sync;
  assign w_stop     = r_scl_sync & r_scl_hist & ~r_sda_hist & r_sda_sync;
  assign w_ptr_inc  = r_ptr + {{(NREGS_LOG2-1){1'b0}}, 1'b1};
  assign w_rd_cur   = r_regs[r_ptr];
  assign w_rd_inc   = r_regs[w_ptr_inc];

  // Bring the asynchronous bus lines into the clock domain and keep one sample of history.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_scl_meta <= 1'b1;
      r_scl_sync <= 1'b1;
      r_scl_hist <= 1'b1;
      r_sda_meta <= 1'b1;
      r_sda_sync <= 1'b1;
      r_sda_hist <= 1'b1;
    end else begin
      r_scl_meta <= scl_i;
      r_scl_sync <= r_scl_meta;
      r_scl_hist <= r_scl_sync;
      r_sda_meta <= sda_i;
      r_sda_sync <= r_sda_meta;
      r_sda_hist <= r_sda_sync;
    end
  end

  // FSM state register and all registered outputs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state   <= S_IDLE;
      r_bitcnt  <= 4'd0;
      r_shift   <= 8'h00;
      r_mack    <= 1'b1;
      r_ptr     <= '0;
      r_sda_oe  <= 1'b0;
      r_busy    <= 1'b0;
      r_wr_stb  <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= 8'h00;
    end else begin
      r_state   <= w_state_nxt;
      r_bitcnt  <= w_bitcnt_nxt;
      r_shift   <= w_shift_nxt;
      r_mack    <= w_mack_nxt;
      r_ptr     <= w_ptr_nxt;
      r_sda_oe  <= w_sda_oe_nxt;
      r_busy    <= w_busy_nxt;
      r_wr_stb  <= w_wr_stb_nxt;
      r_wr_addr <= w_wr_addr_nxt;
      r_wr_data <= w_wr_data_nxt;
    end
  end

  // Next-state logic: START/STOP override every state, otherwise step the byte protocol.
  always_comb begin
    w_state_nxt   = r_state;
    w_bitcnt_nxt  = r_bitcnt;
    w_shift_nxt   = r_shift;
    w_mack_nxt    = r_mack;
    w_ptr_nxt     = r_ptr;
    w_sda_oe_nxt  = r_sda_oe;
    w_busy_nxt    = r_busy;
    w_wr_stb_nxt  = 1'b0;
    w_wr_addr_nxt = r_wr_addr;
    w_wr_data_nxt = r_wr_data;
    w_we          = 1'b0;

    if (w_start) begin
      // A partially shifted byte is simply dropped.
      w_state_nxt  = S_ADDR;
      w_bitcnt_nxt = 4'd0;
      w_sda_oe_nxt = 1'b0;
    end else if (w_stop) begin
      w_state_nxt  = S_IDLE;
      w_bitcnt_nxt = 4'd0;
      w_sda_oe_nxt = 1'b0;
      w_busy_nxt   = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_sda_oe_nxt = 1'b0;
        end
        S_ADDR: begin
          if (w_scl_rise && (r_bitcnt != 4'd8)) begin
            w_shift_nxt  = {r_shift[6:0], r_sda_sync};
            w_bitcnt_nxt = r_bitcnt + 4'd1;
          end else if (w_scl_fall && (r_bitcnt == 4'd8)) begin
            w_bitcnt_nxt = 4'd0;
            if (r_shift[7:1] == DEV_ADDR) begin
              w_state_nxt  = S_ACK_A;
              w_sda_oe_nxt = 1'b1;
              w_busy_nxt   = 1'b1;
            end else begin
              w_state_nxt  = S_IGNORE;
              w_busy_nxt   = 1'b0;
            end
          end else begin
            w_state_nxt = S_ADDR;
          end
        end
        S_ACK_A: begin
          // r_shift[0] still holds the R/W bit of the address byte.
          if (w_scl_fall) begin
            w_bitcnt_nxt = 4'd0;
            if (r_shift[0]) begin
              w_state_nxt  = S_RDATA;
              w_shift_nxt  = w_rd_cur;
              w_sda_oe_nxt = ~w_rd_cur[7];
            end else begin
              w_state_nxt  = S_REG;
              w_sda_oe_nxt = 1'b0;
            end
          end else begin
            w_sda_oe_nxt = 1'b1;
          end
        end
        S_REG: begin
          if (w_scl_rise && (r_bitcnt != 4'd8)) begin
            w_shift_nxt  = {r_shift[6:0], r_sda_sync};
            w_bitcnt_nxt = r_bitcnt + 4'd1;
          end else if (w_scl_fall && (r_bitcnt == 4'd8)) begin
            w_ptr_nxt    = r_shift[NREGS_LOG2-1:0];
            w_bitcnt_nxt = 4'd0;
            w_state_nxt  = S_ACK_R;
            w_sda_oe_nxt = 1'b1;
          end else begin
            w_state_nxt = S_REG;
          end
        end
        S_ACK_R: begin
          if (w_scl_fall) begin
            w_state_nxt  = S_WDATA;
            w_sda_oe_nxt = 1'b0;
          end else begin
            w_sda_oe_nxt = 1'b1;
          end
        end
        S_WDATA: begin
          if (w_scl_rise && (r_bitcnt != 4'd8)) begin
            w_shift_nxt  = {r_shift[6:0], r_sda_sync};
            w_bitcnt_nxt = r_bitcnt + 4'd1;
          end else if (w_scl_fall && (r_bitcnt == 4'd8)) begin
            w_bitcnt_nxt = 4'd0;
            w_state_nxt  = S_ACK_W;
            w_sda_oe_nxt = 1'b1;
          end else begin
            w_state_nxt = S_WDATA;
          end
        end
        S_ACK_W: begin
          // The byte commits only once its ACK has been completed.
          if (w_scl_fall) begin
            w_we          = 1'b1;
            w_wr_stb_nxt  = 1'b1;
            w_wr_addr_nxt = r_ptr;
            w_wr_data_nxt = r_shift;
            w_ptr_nxt     = w_ptr_inc;
            w_state_nxt   = S_WDATA;
            w_sda_oe_nxt  = 1'b0;
          end else begin
            w_sda_oe_nxt = 1'b1;
          end
        end
        S_RDATA: begin
          // Bit 7 of r_shift is always the bit currently presented on the bus.
          if (w_scl_rise && (r_bitcnt != 4'd8)) begin
            w_bitcnt_nxt = r_bitcnt + 4'd1;
          end else if (w_scl_fall && (r_bitcnt == 4'd8)) begin
            w_bitcnt_nxt = 4'd0;
            w_state_nxt  = S_MACK;
            w_sda_oe_nxt = 1'b0;
          end else if (w_scl_fall && (r_bitcnt != 4'd0)) begin
            w_shift_nxt  = {r_shift[6:0], 1'b0};
            w_sda_oe_nxt = ~r_shift[6];
          end else begin
            w_state_nxt = S_RDATA;
          end
        end
        S_MACK: begin
          if (w_scl_rise) begin
            w_mack_nxt = r_sda_sync;
          end else if (w_scl_fall) begin
            w_ptr_nxt = w_ptr_inc;
            if (!r_mack) begin
              w_state_nxt  = S_RDATA;
              w_shift_nxt  = w_rd_inc;
              w_sda_oe_nxt = ~w_rd_inc[7];
            end else begin
              w_state_nxt  = S_IGNORE;
              w_sda_oe_nxt = 1'b0;
              w_busy_nxt   = 1'b0;
            end
          end else begin
            w_sda_oe_nxt = 1'b0;
          end
        end
        S_IGNORE: begin
          w_sda_oe_nxt = 1'b0;
        end
        default: begin
          w_state_nxt  = S_IDLE;
          w_sda_oe_nxt = 1'b0;
          w_busy_nxt   = 1'b0;
        end
      endcase
    end
  end

  // Register file: written when a data byte's ACK completes.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= RESET_VAL;
      end
    end else if (w_we) begin
      r_regs[r_ptr] <= r_shift;
    end
  end

  // Read-back port: one cycle of latency; a write in the same cycle shows up one cycle later.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_rd_data <= 8'h00;
    end else begin
      r_rd_data <= r_regs[rd_addr_i];
    end
  end

  assign sda_oe_o  = r_sda_oe;
  assign wr_stb_o  = r_wr_stb;
  assign wr_addr_o = r_wr_addr;
  assign wr_data_o = r_wr_data;
  assign rd_data_o = r_rd_data;
  assign busy_o    = r_busy;

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Directed bench for i2c_target_regfile: a bit-banged I2C master drives the
// bus, and the expected values below are computed by hand.
module tb_i2c_target_regfile;

  localparam int Q = 10;  // quarter SCL period in clk cycles (SCL = clk/40)

  logic       clk = 1'b0;
  logic       rst_n;
  logic       m_scl, m_sda;
  logic       sda_bus;
  logic       sda_oe;
  logic       wr_stb;
  logic [7:0] wr_addr, wr_data;
  logic [7:0] rd_addr;
  logic [7:0] rd_data;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Monitor state.
  int         stb_cnt     = 0;
  int         oe_cycles   = 0;
  int         busy_cycles = 0;
  logic [7:0] last_addr   = 8'h00;
  logic [7:0] last_data   = 8'h00;
  logic [7:0] rd_at_stb   = 8'h00;
  logic [7:0] rd_after    = 8'h00;
  logic       arm         = 1'b0;

  always #5 clk = ~clk;

  assign sda_bus = m_sda & ~sda_oe;

  i2c_target_regfile dut (
    .clk_i     (clk),
    .rst_n_i   (rst_n),
    .scl_i     (m_scl),
    .sda_i     (sda_bus),
    .sda_oe_o  (sda_oe),
    .wr_stb_o  (wr_stb),
    .wr_addr_o (wr_addr),
    .wr_data_o (wr_data),
    .rd_addr_i (rd_addr),
    .rd_data_o (rd_data),
    .busy_o    (busy)
  );

  // Count strobes, SDA drive and busy cycles; watch the same-cycle read of index 0xFF.
  always @(negedge clk) begin
    if (sda_oe) oe_cycles = oe_cycles + 1;
    if (busy) busy_cycles = busy_cycles + 1;
    if (wr_stb) begin
      stb_cnt   = stb_cnt + 1;
      last_addr = wr_addr;
      last_data = wr_data;
    end
    if (wr_stb && (wr_addr == 8'hFF) && (rd_addr == 8'hFF)) begin
      rd_at_stb = rd_data;
      arm       = 1'b1;
    end else if (arm) begin
      rd_after = rd_data;
      arm      = 1'b0;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wq(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; wq(Q);
    m_scl = 1'b1; wq(Q);
    m_sda = 1'b0; wq(Q);
    m_scl = 1'b0; wq(Q);
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; wq(Q);
    m_scl = 1'b1; wq(Q);
    m_sda = 1'b1; wq(Q);
  endtask

  task automatic send_bit(input logic b);
    m_sda = b;    wq(Q);
    m_scl = 1'b1; wq(2 * Q);
    m_scl = 0;    wq(Q);
  endtask

  // Write one byte; ack reports whether the target drove SDA during the 9th SCL high.
  task automatic write_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    m_sda = 1'b1; wq(Q);
    m_scl = 1'b1; wq(Q);
    @(negedge clk);
    ack = sda_oe;
    wq(Q);
    m_scl = 1'b0; wq(Q);
  endtask

  // Read one byte, then send mack; oe_mack reports target SDA drive during the MACK bit.
  task automatic read_byte(input logic mack, output logic [7:0] d, output logic oe_mack);
    for (int i = 7; i >= 0; i--) begin
      m_sda = 1'b1; wq(Q);
      m_scl = 1'b1; wq(Q);
      @(negedge clk);
      d[i] = sda_bus;
      wq(Q);
      m_scl = 1'b0; wq(Q);
    end
    m_sda = mack; wq(Q);
    m_scl = 1'b1; wq(Q);
    @(negedge clk);
    oe_mack = sda_oe;
    wq(Q);
    m_scl = 1'b0; wq(Q);
  endtask

  task automatic peek(input logic [7:0] a, output logic [7:0] d);
    @(negedge clk);
    rd_addr = a;
    @(negedge clk);
    d = rd_data;
  endtask

  initial begin
    logic       ack;
    logic       oe_m;
    logic [7:0] d;
    int         s0, o0, b0;

    rst_n = 1'b0; m_scl = 1'b1; m_sda = 1'b1; rd_addr = 8'h00;
    wq(5);
    @(negedge clk);
    check_eq("rst_sda_oe", sda_oe, 1'b0);
    check_eq("rst_wr_stb", wr_stb, 1'b0);
    check_eq("rst_wr_addr", wr_addr, 8'h00);
    check_eq("rst_wr_data", wr_data, 8'h00);
    check_eq("rst_rd_data", rd_data, 8'h00);
    check_eq("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    wq(5);

    // Single write 0x72 0x41 0x10.
    s0 = stb_cnt;
    i2c_start();
    write_byte(8'h72, ack); check_eq("w1_ack_addr", ack, 1'b1);
    check_eq("w1_busy", busy, 1'b1);
    write_byte(8'h41, ack); check_eq("w1_ack_reg", ack, 1'b1);
    write_byte(8'h10, ack); check_eq("w1_ack_data", ack, 1'b1);
    i2c_stop(); wq(5);
    check_eq("w1_stb_cnt", stb_cnt - s0, 1);
    check_eq("w1_wr_addr", last_addr, 8'h41);
    check_eq("w1_wr_data", last_data, 8'h10);
    check_eq("w1_busy_after_stop", busy, 1'b0);
    peek(8'h41, d); check_eq("w1_rd_41", d, 8'h10);

    // Address mismatch 0x74: target stays silent.
    s0 = stb_cnt; o0 = oe_cycles; b0 = busy_cycles;
    i2c_start();
    write_byte(8'h74, ack); check_eq("mm_ack_addr", ack, 1'b0);
    write_byte(8'h41, ack);
    write_byte(8'h55, ack);
    i2c_stop(); wq(5);
    check_eq("mm_oe_cycles", oe_cycles - o0, 0);
    check_eq("mm_busy_cycles", busy_cycles - b0, 0);
    check_eq("mm_stb_cnt", stb_cnt - s0, 0);
    peek(8'h41, d); check_eq("mm_rd_41", d, 8'h10);

    // Burst write with pointer wrap; watch index 0xFF on the read port meanwhile.
    s0 = stb_cnt;
    @(negedge clk); rd_addr = 8'hFF;
    i2c_start();
    write_byte(8'h72, ack); check_eq("bw_ack_addr", ack, 1'b1);
    write_byte(8'hFE, ack);
    write_byte(8'hA1, ack);
    write_byte(8'hB2, ack);
    write_byte(8'hC3, ack); check_eq("bw_ack_last", ack, 1'b1);
    i2c_stop(); wq(5);
    check_eq("bw_stb_cnt", stb_cnt - s0, 3);
    check_eq("bw_last_addr", last_addr, 8'h00);
    check_eq("bw_rd_old_same_cycle", rd_at_stb, 8'h00);
    check_eq("bw_rd_new_next_cycle", rd_after, 8'hB2);
    peek(8'hFE, d); check_eq("bw_rd_FE", d, 8'hA1);
    peek(8'hFF, d); check_eq("bw_rd_FF", d, 8'hB2);
    peek(8'h00, d); check_eq("bw_rd_00", d, 8'hC3);

    // Pointer write, repeated START, read two bytes (ACK then NACK).
    i2c_start();
    write_byte(8'h72, ack);
    write_byte(8'hFE, ack); check_eq("rd_ack_ptr", ack, 1'b1);
    i2c_start();
    write_byte(8'h73, ack); check_eq("rd_ack_addr", ack, 1'b1);
    read_byte(1'b0, d, oe_m);
    check_eq("rd_byte0", d, 8'hA1);
    check_eq("rd_mack0_released", oe_m, 1'b0);
    read_byte(1'b1, d, oe_m);
    check_eq("rd_byte1", d, 8'hB2);
    check_eq("rd_mack1_released", oe_m, 1'b0);
    wq(Q);
    check_eq("rd_after_nack_oe", sda_oe, 1'b0);
    check_eq("rd_after_nack_busy", busy, 1'b0);
    i2c_stop(); wq(5);
    // Pointer is now 0x00: a read without pointer write returns reg[0x00].
    i2c_start();
    write_byte(8'h73, ack);
    read_byte(1'b1, d, oe_m);
    check_eq("rd_ptr_wrapped", d, 8'hC3);
    i2c_stop(); wq(5);

    // START after 4 data bits aborts that byte.
    s0 = stb_cnt;
    i2c_start();
    write_byte(8'h72, ack);
    write_byte(8'h20, ack);
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    i2c_start();
    write_byte(8'h72, ack); check_eq("ab_ack_addr", ack, 1'b1);
    write_byte(8'h21, ack);
    write_byte(8'h66, ack);
    i2c_stop(); wq(5);
    check_eq("ab_stb_cnt", stb_cnt - s0, 1);
    peek(8'h20, d); check_eq("ab_rd_20", d, 8'h00);
    peek(8'h21, d); check_eq("ab_rd_21", d, 8'h66);

    // Reset while driving the address ACK.
    i2c_start();
    for (int i = 7; i >= 0; i--) send_bit(((8'h72 >> i) & 8'h01) != 8'h00);
    m_sda = 1'b1; wq(Q);
    m_scl = 1'b1; wq(5);
    @(negedge clk);
    check_eq("rs_oe_before", sda_oe, 1'b1);
    rst_n = 1'b0;
    #1;
    check_eq("rs_oe_async", sda_oe, 1'b0);
    check_eq("rs_busy_async", busy, 1'b0);
    wq(3);
    @(negedge clk);
    m_scl = 1'b1; m_sda = 1'b1; rst_n = 1'b1;
    wq(5);
    peek(8'h41, d); check_eq("rs_rd_41", d, 8'h00);
    peek(8'hFF, d); check_eq("rs_rd_FF", d, 8'h00);
    s0 = stb_cnt;
    i2c_start();
    write_byte(8'h72, ack); check_eq("rs_next_ack", ack, 1'b1);
    write_byte(8'h05, ack);
    write_byte(8'h99, ack);
    i2c_stop(); wq(5);
    check_eq("rs_next_stb", stb_cnt - s0, 1);
    peek(8'h05, d); check_eq("rs_rd_05", d, 8'h99);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
